// File: rtl/rejestry_pkg.sv
// Shared types and helpers for the Rx register-file save/restore engine.
// The state encoding and the index-width helper live here so that the
// engine and anything that observes it agree on them.
package rejestry_pkg;

  // Engine states: idle, save sweep, restore sweep, one-cycle completion.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ZRZUT  = 2'd1,
    WCZYT  = 2'd2,
    KONIEC = 2'd3
  } stan_t;

  // Default geometry of the register file.
  localparam int RX_LICZBA_DOM = 8;
  localparam int RX_ROZM_DOM   = 8;

  // Width of the register index for a file of n registers (n >= 2).
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Index width for the default geometry.
  localparam int RX_IDX_W_DOM = idx_w(RX_LICZBA_DOM);

endpackage

// File: rtl/rejestry_zrzut.sv
// Context save/restore engine for the Rx register file.
// Save sweeps registers 0..N-1 through the file port and streams them out
// over so_*; restore accepts a si_* stream and writes registers 0..N-1.
// While busy is high the engine owns rx_wr/rx_nr/rx_dane.
// Optional build macro REJ_ZRZUT_MASKA_EN adds a per-register mask port
// (maska) sampled at start; masked-off registers are skipped one per cycle.
module rejestry_zrzut
  import rejestry_pkg::*;
#(
  parameter int Rx_liczba    = 8,
  parameter int Rx_rozm_data = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start_zrzut,
  input  logic                          start_wczyt,
`ifdef REJ_ZRZUT_MASKA_EN
  input  logic [Rx_liczba-1:0]          maska,
`endif
  output logic                          busy,
  output logic                          done,
  output logic                          rx_wr,
  output logic [idx_w(Rx_liczba)-1:0]   rx_nr,
  output logic [Rx_rozm_data-1:0]       rx_dane,
  input  logic [Rx_rozm_data-1:0]       rx_out,
  output logic [Rx_rozm_data-1:0]       so_data,
  output logic                          so_valid,
  input  logic                          so_ready,
  output logic                          so_last,
  input  logic [Rx_rozm_data-1:0]       si_data,
  input  logic                          si_valid,
  output logic                          si_ready
);

  localparam int IW = idx_w(Rx_liczba);
  localparam logic [IW-1:0] LAST = IW'(Rx_liczba - 1);

  stan_t                   state, state_next;
  logic [IW-1:0]           idx, idx_next;
  // Set once the sweep has addressed the final register; keeps the index
  // from stepping past N-1 while the last beat drains.
  logic                    sweep_done, sweep_done_next;
  logic [Rx_rozm_data-1:0] so_data_next;
  logic                    so_valid_next, so_last_next;
  logic                    hs;
  logic                    bit_en;
  logic [IW-1:0]           last_idx;

`ifdef REJ_ZRZUT_MASKA_EN
  logic [Rx_liczba-1:0]    maska_reg;

  // Capture the mask when an operation is accepted in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      maska_reg <= '0;
    end else if (state == IDLE && (start_zrzut || start_wczyt)) begin
      maska_reg <= maska;
    end
  end

  // Highest enabled register: the save beat that carries so_last.
  always_comb begin
    last_idx = '0;
    for (int i = 0; i < Rx_liczba; i++) begin
      if (maska_reg[i]) last_idx = IW'(i);
    end
  end

  assign bit_en = maska_reg[idx];
`else
  assign last_idx = LAST;
  assign bit_en   = 1'b1;
`endif

  assign busy  = (state != IDLE);
  assign done  = (state == KONIEC);
  assign rx_nr = idx;

  // State, index and save-stream output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      sweep_done <= 1'b0;
      so_data    <= '0;
      so_valid   <= 1'b0;
      so_last    <= 1'b0;
    end else begin
      state      <= state_next;
      idx        <= idx_next;
      sweep_done <= sweep_done_next;
      so_data    <= so_data_next;
      so_valid   <= so_valid_next;
      so_last    <= so_last_next;
    end
  end

  // Next-state logic and the register-file / restore-stream handshakes.
  always_comb begin
    state_next      = state;
    idx_next        = idx;
    sweep_done_next = sweep_done;
    so_data_next    = so_data;
    so_valid_next   = so_valid;
    so_last_next    = so_last;
    hs              = so_valid && so_ready;
    si_ready        = 1'b0;
    rx_wr           = 1'b0;
    rx_dane         = '0;

    case (state)
      IDLE: begin
        idx_next        = '0;
        sweep_done_next = 1'b0;
        if (start_zrzut) begin
          state_next = ZRZUT;
        end else if (start_wczyt) begin
          state_next = WCZYT;
        end
      end

      ZRZUT: begin
        // Drain side: a handshake empties the output register; the final
        // beat ends the operation.
        if (hs) begin
          so_valid_next = 1'b0;
          if (so_last) begin
            so_last_next = 1'b0;
            state_next   = KONIEC;
          end
        end
        // Fill side: one register addressed per cycle until the sweep ends.
        if (!sweep_done && !(hs && so_last)) begin
          if (!bit_en) begin
            // Masked-off register: step past it without a beat.
            if (idx == LAST) begin
              sweep_done_next = 1'b1;
              // Nothing left in flight (e.g. empty mask): finish now.
              if (!so_valid) state_next = KONIEC;
            end else begin
              idx_next = idx + 1'b1;
            end
          end else if (!so_valid || so_ready) begin
            so_data_next  = rx_out;
            so_valid_next = 1'b1;
            so_last_next  = (idx == last_idx);
            if (idx == LAST) begin
              sweep_done_next = 1'b1;
            end else begin
              idx_next = idx + 1'b1;
            end
          end
        end
      end

      WCZYT: begin
        si_ready = bit_en;
        rx_dane  = si_data;
        rx_wr    = si_valid && bit_en;
        if (!bit_en) begin
          // Masked-off register: skip without consuming a beat.
          if (idx == LAST) begin
            state_next = KONIEC;
          end else begin
            idx_next = idx + 1'b1;
          end
        end else if (si_valid) begin
          if (idx == LAST || idx == last_idx) begin
            state_next = KONIEC;
          end else begin
            idx_next = idx + 1'b1;
          end
        end
      end

      KONIEC: begin
        // Clear the index so rx_nr reads 0 once back in IDLE.
        idx_next        = '0;
        sweep_done_next = 1'b0;
        state_next      = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_rejestry_zrzut.sv
// Self-checking bench for rejestry_zrzut: bench-owned register file,
// reference register contents, scoreboard queue for the save stream and
// a free-running monitor. Builds with or without REJ_ZRZUT_MASKA_EN.
module tb_rejestry_zrzut;
  localparam int N  = 8;
  localparam int W  = 8;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_zrzut = 1'b0, start_wczyt = 1'b0;
  logic          busy, done, rx_wr, so_valid, so_last, si_ready;
  logic [IW-1:0] rx_nr;
  logic [W-1:0]  rx_dane, rx_out, so_data;
  logic          so_ready = 1'b1;
  logic [W-1:0]  si_data = '0;
  logic          si_valid = 1'b0;
`ifdef REJ_ZRZUT_MASKA_EN
  logic [N-1:0]  maska_tb = '1;
`endif

  always #5 clk = ~clk;

  rejestry_zrzut #(.Rx_liczba(N), .Rx_rozm_data(W)) dut (
    .clk(clk), .rst(rst), .start_zrzut(start_zrzut), .start_wczyt(start_wczyt),
`ifdef REJ_ZRZUT_MASKA_EN
    .maska(maska_tb),
`endif
    .busy(busy), .done(done), .rx_wr(rx_wr), .rx_nr(rx_nr), .rx_dane(rx_dane),
    .rx_out(rx_out), .so_data(so_data), .so_valid(so_valid), .so_ready(so_ready),
    .so_last(so_last), .si_data(si_data), .si_valid(si_valid), .si_ready(si_ready)
  );

  // Register file attached to the engine, plus a bench-side preload port.
  logic [W-1:0]  rf [N];
  logic [W-1:0]  ref_rf [N];
  logic          tb_we = 1'b0;
  logic [IW-1:0] tb_addr = '0;
  logic [W-1:0]  tb_din = '0;

  assign rx_out = rf[rx_nr];

  always @(posedge clk) begin
    if (rx_wr) rf[rx_nr] <= rx_dane;
    else if (tb_we) rf[tb_addr] <= tb_din;
  end

  typedef struct { logic [W-1:0] d; logic l; } beat_t;
  beat_t exp_q[$];

  int n_chk = 0, n_fail = 0, done_cnt = 0, beat_cnt = 0;
  int rdy_mode = 0;
  logic in_save = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic bit en(input int i);
`ifdef REJ_ZRZUT_MASKA_EN
    return maska_tb[i];
`else
    return 1'b1;
`endif
  endfunction

  // so_ready pattern generator: 0 = always ready, 1 = 1,0,0 repeating, 2 = random.
  initial begin
    int ph;
    ph = 0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: so_ready = 1'b1;
        1: begin so_ready = (ph % 3 == 0); ph++; end
        default: so_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: scoreboard on save beats, stall stability, write-enable rule.
  initial begin
    logic prev_stall;
    logic [W-1:0] prev_data;
    beat_t b;
    prev_stall = 1'b0;
    prev_data = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (done) done_cnt++;
        chk("rx_wr_rule", {31'd0, rx_wr}, {31'd0, si_valid && si_ready});
        if (in_save) chk("si_ready_in_save", {31'd0, si_ready}, 32'd0);
        if (prev_stall) begin
          chk("stall_valid", {31'd0, so_valid}, 32'd1);
          chk("stall_data", {24'd0, so_data}, {24'd0, prev_data});
        end
        if (so_valid && so_ready) begin
          beat_cnt++;
          if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_beat: got %0h expected none", so_data);
          end else begin
            b = exp_q.pop_front();
            chk("beat_data", {24'd0, so_data}, {24'd0, b.d});
            chk("beat_last", {31'd0, so_last}, {31'd0, b.l});
          end
        end
        prev_stall = so_valid && !so_ready;
        prev_data  = so_data;
      end
    end
  end

  task automatic preload(input logic [W-1:0] v [N]);
    for (int i = 0; i < N; i++) begin
      tb_addr = IW'(i); tb_din = v[i]; tb_we = 1'b1;
      @(posedge clk); #1;
      ref_rf[i] = v[i];
    end
    tb_we = 1'b0;
  endtask

  task automatic check_rf(input string tag);
    for (int i = 0; i < N; i++) chk(tag, {24'd0, rf[i]}, {24'd0, ref_rf[i]});
  endtask

  // Save: model = enabled registers in ascending order, last on the highest.
  task automatic do_save(input int rmode, input bit poke, input bit chk_lat);
    int cyc, hi, npop, bc0, dc0;
    rdy_mode = rmode;
    hi = -1; npop = 0;
    for (int i = 0; i < N; i++) if (en(i)) begin hi = i; npop++; end
    for (int i = 0; i < N; i++) if (en(i)) exp_q.push_back('{ref_rf[i], (i == hi)});
    bc0 = beat_cnt; dc0 = done_cnt;
    @(posedge clk); #1;
    start_zrzut = 1'b1; start_wczyt = poke;
    in_save = 1'b1; si_valid = 1'b1; si_data = 8'hEE;
    @(posedge clk); #1;
    start_zrzut = 1'b0; start_wczyt = 1'b0;
    cyc = 1;
    while (1) begin
      @(negedge clk);
      if (done) break;
      start_wczyt = poke && (cyc == 4);
      start_zrzut = poke && (cyc == 6);
      cyc++;
      if (cyc > 300) break;
    end
    chk("save_done_seen", {31'd0, done}, 32'd1);
    if (chk_lat) chk("save_latency", cyc, N + 2);
    start_wczyt = 1'b0; start_zrzut = 1'b0;
    @(posedge clk); #1;
    chk("busy_after_save", {31'd0, busy}, 32'd0);
    chk("save_beats", beat_cnt - bc0, npop);
    chk("save_done_cnt", done_cnt - dc0, 1);
    chk("save_queue_empty", exp_q.size(), 0);
    in_save = 1'b0; si_valid = 1'b0;
  endtask

  // Restore of all registers with random valid gaps; optional reset after
  // abort_after accepted beats.
  task automatic do_restore(input logic [W-1:0] d [N], input int gapmax, input int abort_after);
    int dc0, t;
`ifdef REJ_ZRZUT_MASKA_EN
    maska_tb = '1;
`endif
    dc0 = done_cnt;
    @(posedge clk); #1; start_wczyt = 1'b1;
    @(posedge clk); #1; start_wczyt = 1'b0;
    for (int i = 0; i < N; i++) begin
      si_valid = 1'b0;
      repeat ($urandom_range(0, gapmax)) begin @(posedge clk); #1; end
      si_valid = 1'b1; si_data = d[i];
      t = 0;
      while (1) begin
        @(negedge clk);
        if (si_ready) break;
        t++;
        if (t > 50) break;
      end
      chk("restore_ready", {31'd0, si_ready}, 32'd1);
      @(posedge clk); #1;
      ref_rf[i] = d[i];
      if (i + 1 == abort_after) begin
        si_data = ~d[i];
        rst = 1'b1;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_rx_wr", {31'd0, rx_wr}, 32'd0);
        chk("abort_so_valid", {31'd0, so_valid}, 32'd0);
        chk("abort_so_last", {31'd0, so_last}, 32'd0);
        chk("abort_so_data", {24'd0, so_data}, 32'd0);
        chk("abort_si_ready", {31'd0, si_ready}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; si_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_no_done", done_cnt - dc0, 0);
        return;
      end
    end
    si_valid = 1'b0;
    @(negedge clk);
    chk("restore_done_seen", {31'd0, done}, 32'd1);
    @(posedge clk); #1;
    chk("busy_after_restore", {31'd0, busy}, 32'd0);
    chk("restore_done_cnt", done_cnt - dc0, 1);
  endtask

  initial begin
    logic [W-1:0] v [N];
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_so_valid", {31'd0, so_valid}, 32'd0);
    chk("rst_so_last", {31'd0, so_last}, 32'd0);
    chk("rst_so_data", {24'd0, so_data}, 32'd0);
    chk("rst_rx_wr", {31'd0, rx_wr}, 32'd0);
    chk("rst_rx_nr", {29'd0, rx_nr}, 32'd0);
    chk("rst_si_ready", {31'd0, si_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Full-speed save of 10..17, then the same save with a stalling sink.
    for (int i = 0; i < N; i++) v[i] = W'(8'h10 + i);
    preload(v);
    do_save(0, 1'b0, 1'b1);
    check_rf("rf_after_save");
    do_save(1, 1'b0, 1'b0);

    // Restore A0..A7 with gaps.
    for (int i = 0; i < N; i++) v[i] = W'(8'hA0 + i);
    do_restore(v, 3, 0);
    check_rf("rf_after_restore");

    // Simultaneous starts plus extra starts mid-save: save only.
    do_save(2, 1'b1, 1'b0);
    check_rf("rf_after_poke");

    // Reset after the third restore beat.
    for (int i = 0; i < N; i++) v[i] = W'(8'hB0 + i);
    do_restore(v, 2, 3);
    check_rf("rf_after_abort");

    // Randomised mix of restores and saves.
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < N; i++) v[i] = W'($urandom);
      if (k % 2 == 0) do_restore(v, 3, 0);
      else preload(v);
      do_save(2, 1'b0, 1'b0);
      check_rf("rf_random");
    end

`ifdef REJ_ZRZUT_MASKA_EN
    for (int i = 0; i < N; i++) v[i] = W'(8'h10 + i);
    preload(v);
    maska_tb = 8'b1000_0101;
    do_save(0, 1'b0, 1'b0);
    maska_tb = 8'b0000_0000;
    do_save(0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      maska_tb = N'($urandom);
      do_save(2, 1'b0, 1'b0);
    end
    maska_tb = '1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
